ysyx_24120013_isram: RTL

Instruction-memory responder sitting on the fetch side of the NPC core, answering the IFU's instruction-fetch requests. Accepts one word-aligned fetch address per valid/ready handshake, returns the 32-bit instruction after a fixed or randomised latency, and flags misaligned or out-of-range fetches. Contents are filled through a simulation load port before reset is released. Only one request is outstanding at a time.

---
 rtl/ysyx_24120013_mem_pkg.sv | 17 +
 rtl/ysyx_24120013_lfsr8.sv | 32 +++
 rtl/ysyx_24120013_isram.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ysyx_24120013_mem_pkg.sv
// Shared types and constants for the fetch-side instruction memory responder.
// Holds the FSM state encoding, default base address and LFSR seed/taps.
package ysyx_24120013_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3 of the state.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ysyx_24120013_lfsr8.sv
// 8-bit Fibonacci LFSR used to pick a per-request fetch latency.
// Shifts left one step on each cycle en_i is high; reseeds on reset.
module ysyx_24120013_lfsr8
  import ysyx_24120013_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/ysyx_24120013_isram.sv
// Instruction-memory responder for the IFU: one outstanding fetch, fixed latency,
// or LFSR-randomised latency when YSYX_24120013_ISRAM_RAND_DELAY_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid must be held until that edge, and ready may depend on state only.
module ysyx_24120013_isram
  import ysyx_24120013_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output state_e                dbg_state_o
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  enter_resp;
  logic [3:0]            lat_sel;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [ADDR_WIDTH-1:0] lk_off;
  logic [DEPTH_LOG2-1:0] lk_idx;
  logic                  lk_err;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef YSYX_24120013_ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_state;
  logic       unused_lfsr;

  ysyx_24120013_lfsr8 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept),
    .state_o (lfsr_state)
  );

  assign lat_sel     = {1'b0, lfsr_state[2:0]} + 4'd1;
  assign unused_lfsr = ^lfsr_state[7:3];
`else
  assign lat_sel = 4'(LATENCY);
`endif

  // A latency-1 request goes straight to RESP, so the lookup must see the live address.
  assign lk_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign lk_off  = lk_addr - BASE_ADDR;
  assign lk_idx  = lk_off[DEPTH_LOG2+1:2];
  assign lk_err  = (lk_addr[1:0] != 2'b00) || ((lk_off >> (DEPTH_LOG2 + 2)) != '0);

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          cnt_d  = lat_sel - 4'd1;
          if (lat_sel > 4'd1) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          cnt_d      = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Same-edge load writes land after this read, so the old word is returned.
    if (enter_resp) begin
      data_d = lk_err ? '0 : mem[lk_idx];
      err_d  = lk_err;
    end
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    resp_data   = data_q;
    resp_err    = err_q;
    dbg_state_o = state_q;
  end

endmodule
